jtframe_mr_ddrarb: RTL and testbench

Parametrised, burst-aware arbiter that shares the MiSTer DDR3 Avalon-MM port among `CH` requesters (ROM download, frame-buffer rotation, core-side users). It replaces the plain two-way mux: grants are held for a whole burst, so switching between channels never corrupts a transfer. It sits between the jtframe MiSTer top level and the HPS DDR bridge.

---
 rtl/jtframe_mr_ddrarb.sv | 158 +++++++++++++++
 tb/tb_jtframe_mr_ddrarb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mr_ddrarb.sv
// Burst-aware arbiter sharing one DDR Avalon-MM port among CH requesters.
// A grant is held for a whole read or write burst; channel 0 always has priority.
module jtframe_mr_ddrarb #(
    parameter int CH = 2,
    parameter int AW = 29,
    parameter int BW = 8,
    parameter int DW = 64,
    parameter int RR = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lock,
    input  logic [CH-1:0]        ch_rd,
    input  logic [CH-1:0]        ch_we,
    input  logic [CH*AW-1:0]     ch_addr,
    input  logic [CH*BW-1:0]     ch_burstcnt,
    input  logic [CH*DW/8-1:0]   ch_be,
    input  logic [CH*DW-1:0]     ch_din,
    output logic [CH-1:0]        ch_busy,
    output logic [CH-1:0]        ch_dout_ready,
    output logic [DW-1:0]        ch_dout,
    input  logic                 ddr_busy,
    input  logic [DW-1:0]        ddr_dout,
    input  logic                 ddr_dout_ready,
    output logic                 ddr_rd,
    output logic                 ddr_we,
    output logic [AW-1:0]        ddr_addr,
    output logic [BW-1:0]        ddr_burstcnt,
    output logic [DW/8-1:0]      ddr_be,
    output logic [DW-1:0]        ddr_din
);
    localparam int GW  = $clog2(CH);
    localparam int BEW = DW/8;
    localparam logic [BW-1:0] ONE = {{(BW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CMD, RDATA, WR} state_t;

    state_t          state;
    logic [GW-1:0]   gnt, last_gnt, nxt_gnt;
    logic [BW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   bc_q;
    logic [CH-1:0]   req;
    logic            any_req, found;
    int              idx;

    logic            g_rd, g_we;
    logic [AW-1:0]   g_addr;
    logic [BW-1:0]   g_bc;
    logic [BEW-1:0]  g_be;
    logic [DW-1:0]   g_din;

    assign g_rd   = ch_rd[gnt];
    assign g_we   = ch_we[gnt];
    assign g_addr = ch_addr[int'(gnt)*AW +: AW];
    assign g_bc   = ch_burstcnt[int'(gnt)*BW +: BW];
    assign g_be   = ch_be[int'(gnt)*BEW +: BEW];
    assign g_din  = ch_din[int'(gnt)*DW +: DW];

    // Channel 0 first; otherwise rotate from the last grant (RR) or lowest index wins.
    always_comb begin
        req = ch_rd | ch_we;
        if (lock) req[CH-1:1] = '0;
        any_req = |req;
        nxt_gnt = '0;
        found   = 1'b0;
        idx     = 0;
        if (!req[0]) begin
            for (int k = 1; k < CH; k++) begin
                idx = (RR != 0) ? ((int'(last_gnt) - 1 + k) % (CH-1)) + 1 : k;
                if (!found && req[idx]) begin
                    nxt_gnt = GW'(idx);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ddr_rd       = 1'b0;
        ddr_we       = 1'b0;
        ddr_addr     = '0;
        ddr_burstcnt = '0;
        ddr_be       = '0;
        ddr_din      = '0;
        case (state)
            CMD: begin
                ddr_rd       = g_rd;
                ddr_we       = g_we;
                ddr_addr     = g_addr;
                ddr_burstcnt = g_bc;
                ddr_be       = g_be;
                ddr_din      = g_din;
            end
            WR: begin
                // Address/burst count stay at their first-beat values for the whole burst
                ddr_we       = g_we;
                ddr_addr     = addr_q;
                ddr_burstcnt = bc_q;
                ddr_be       = g_be;
                ddr_din      = g_din;
            end
            default: ;
        endcase
    end

    assign ch_dout = ddr_dout;

    always_comb begin
        ch_busy       = '1;
        ch_dout_ready = '0;
        for (int i = 0; i < CH; i++) begin
            ch_busy[i]       = ~((GW'(i) == gnt) & (state == CMD || state == WR)) | ddr_busy;
            ch_dout_ready[i] = (GW'(i) == gnt) & (state == RDATA) & ddr_dout_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= '0;
            cnt      <= '0;
            addr_q   <= '0;
            bc_q     <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt      <= nxt_gnt;
                    last_gnt <= nxt_gnt;
                    state    <= CMD;
                end
                CMD: begin
                    addr_q <= g_addr;
                    bc_q   <= g_bc;
                    if (g_rd && !ddr_busy) begin
                        cnt   <= (g_bc == '0) ? ONE : g_bc;
                        state <= RDATA;
                    end else if (g_we && !ddr_busy) begin
                        cnt   <= (g_bc == '0) ? '0 : g_bc - ONE;
                        state <= (g_bc > ONE) ? WR : IDLE;
                    end else if (!g_rd && !g_we) begin
                        state <= IDLE;
                    end
                end
                RDATA: if (ddr_dout_ready) begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) state <= IDLE;
                end
                WR: if (g_we && !ddr_busy) begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_mr_ddrarb.sv
// Scoreboard bench for jtframe_mr_ddrarb: a round-robin and a fixed-priority
// instance share all stimulus; read beats and write beats are checked against queues.
module tb_jtframe_mr_ddrarb;
    localparam int CH = 4, AW = 29, BW = 8, DW = 64, BEW = DW/8;

    logic                clk, rst_n, lock;
    logic [CH-1:0]       ch_rd, ch_we;
    logic [CH*AW-1:0]    ch_addr;
    logic [CH*BW-1:0]    ch_burstcnt;
    logic [CH*BEW-1:0]   ch_be;
    logic [CH*DW-1:0]    ch_din;
    logic                ddr_busy, ddr_dout_ready;
    logic [DW-1:0]       ddr_dout;

    logic [CH-1:0]       ch_busy, ch_dout_ready;
    logic [DW-1:0]       ch_dout;
    logic                ddr_rd, ddr_we;
    logic [AW-1:0]       ddr_addr;
    logic [BW-1:0]       ddr_burstcnt;
    logic [BEW-1:0]      ddr_be;
    logic [DW-1:0]       ddr_din;

    logic [CH-1:0]       f_busy, f_dout_ready;
    logic [DW-1:0]       f_dout;
    logic                f_rd, f_we;
    logic [AW-1:0]       f_addr;
    logic [BW-1:0]       f_burstcnt;
    logic [BEW-1:0]      f_be;
    logic [DW-1:0]       f_din;

    jtframe_mr_ddrarb #(.CH(CH), .AW(AW), .BW(BW), .DW(DW), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n), .lock(lock), .ch_rd(ch_rd), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_burstcnt(ch_burstcnt), .ch_be(ch_be), .ch_din(ch_din),
        .ch_busy(ch_busy), .ch_dout_ready(ch_dout_ready), .ch_dout(ch_dout),
        .ddr_busy(ddr_busy), .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready),
        .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt),
        .ddr_be(ddr_be), .ddr_din(ddr_din));

    jtframe_mr_ddrarb #(.CH(CH), .AW(AW), .BW(BW), .DW(DW), .RR(0)) dut_fix (
        .clk(clk), .rst_n(rst_n), .lock(lock), .ch_rd(ch_rd), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_burstcnt(ch_burstcnt), .ch_be(ch_be), .ch_din(ch_din),
        .ch_busy(f_busy), .ch_dout_ready(f_dout_ready), .ch_dout(f_dout),
        .ddr_busy(ddr_busy), .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready),
        .ddr_rd(f_rd), .ddr_we(f_we), .ddr_addr(f_addr), .ddr_burstcnt(f_burstcnt),
        .ddr_be(f_be), .ddr_din(f_din));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ch; logic [DW-1:0] d; } rd_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [BEW-1:0] be; } wr_t;
    rd_t rq[$];
    wr_t wq[$];
    logic wmon;
    int   errors, checks;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic rd, input logic we, input logic [AW-1:0] a,
                          input logic [BW-1:0] bc, input logic [BEW-1:0] be, input logic [DW-1:0] d);
        ch_rd[i] = rd;
        ch_we[i] = we;
        ch_addr[i*AW +: AW]     = a;
        ch_burstcnt[i*BW +: BW] = bc;
        ch_be[i*BEW +: BEW]     = be;
        ch_din[i*DW +: DW]      = d;
    endtask

    task automatic beat(input int ch, input logic [DW-1:0] d);
        ddr_dout_ready = 1'b1;
        ddr_dout       = d;
        rq.push_back('{ch: ch, d: d});
    endtask

    // Read beats routed to channels and write beats accepted by DDR, popped as they happen
    task automatic monitor();
        rd_t r;
        wr_t w;
        logic [CH-1:0] e;
        forever begin
            @(negedge clk);
            if (ch_dout_ready !== '0) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_stray: ch_dout_ready=%b with no beat expected", ch_dout_ready);
                end else begin
                    r = rq.pop_front();
                    e = '0;
                    e[r.ch] = 1'b1;
                    if (ch_dout_ready !== e || ch_dout !== r.d) begin
                        errors++;
                        $display("FAIL rd_beat: ready=%b data=%h expected ready=%b data=%h",
                                 ch_dout_ready, ch_dout, e, r.d);
                    end
                end
            end
            if (wmon && ddr_we === 1'b1 && ddr_busy === 1'b0) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra: unexpected write beat addr=%h", ddr_addr);
                end else begin
                    w = wq.pop_front();
                    if (ddr_addr !== w.a || ddr_din !== w.d || ddr_be !== w.be) begin
                        errors++;
                        $display("FAIL wr_beat: addr=%h din=%h be=%h expected addr=%h din=%h be=%h",
                                 ddr_addr, ddr_din, ddr_be, w.a, w.d, w.be);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lock = 1'b0; ch_rd = '0; ch_we = '0; ch_addr = '0; ch_burstcnt = '0;
        ch_be = '0; ch_din = '0; ddr_busy = 1'b0; ddr_dout_ready = 1'b0; ddr_dout = '0; wmon = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ch_busy !== 4'hF) begin errors++; $display("FAIL reset_busy: got %b want 1111", ch_busy); end
        checks++;
        if ({ddr_rd, ddr_we, ddr_addr, ddr_burstcnt, ddr_be, ddr_din} !== '0) begin
            errors++; $display("FAIL reset_ddr: rd=%b we=%b addr=%h want all zero", ddr_rd, ddr_we, ddr_addr);
        end
        checks++;
        if (ch_dout_ready !== '0) begin errors++; $display("FAIL reset_rdy: got %b want 0000", ch_dout_ready); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ch_busy !== 4'hF) begin errors++; $display("FAIL idle_busy: got %b want 1111", ch_busy); end
    endtask

    task automatic test_single_read();
        step();
        set_ch(1, 1'b1, 1'b0, 29'h100, 8'd4, '1, '0);
        step();
        @(negedge clk);
        checks++;
        if (ddr_rd !== 1'b1 || ddr_addr !== 29'h100 || ddr_burstcnt !== 8'd4 || ch_busy !== 4'b1101) begin
            errors++;
            $display("FAIL rd_cmd: rd=%b addr=%h bc=%0d busy=%b want 1 100 4 1101", ddr_rd, ddr_addr, ddr_burstcnt, ch_busy);
        end
        for (int b = 0; b < 4; b++) begin
            step();
            if (b == 0) ch_rd[1] = 1'b0;
            beat(1, 64'h11 * (b + 1));
            @(negedge clk);
            checks++;
            if (ddr_rd !== 1'b0) begin errors++; $display("FAIL rd_data_cmd: ddr_rd=%b want 0", ddr_rd); end
        end
        step();
        ddr_dout_ready = 1'b1;
        ddr_dout = 64'hDEAD;
        @(negedge clk);
        checks++;
        if (ch_dout_ready !== '0) begin errors++; $display("FAIL rd_after_burst: ready=%b want 0000", ch_dout_ready); end
        step();
        ddr_dout_ready = 1'b0;
        checks++;
        if (rq.size() != 0) begin errors++; $display("FAIL rd_missing: %0d beats not delivered, want 0", rq.size()); end
    endtask

    task automatic test_lock();
        step();
        lock = 1'b1;
        wmon = 1'b1;
        set_ch(0, 1'b1, 1'b0, 29'h200, 8'd2, '1, '0);
        set_ch(1, 1'b0, 1'b1, 29'h300, 8'd1, 8'hFF, 64'hAB);
        wq.push_back('{a: 29'h300, d: 64'hAB, be: 8'hFF});
        step();
        @(negedge clk);
        checks++;
        if (ch_busy !== 4'b1110 || ddr_rd !== 1'b1 || ddr_addr !== 29'h200) begin
            errors++; $display("FAIL lock_gnt0: busy=%b rd=%b addr=%h want 1110 1 200", ch_busy, ddr_rd, ddr_addr);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 0) begin ch_rd[0] = 1'b0; lock = 1'b0; end
            if (c < 2) beat(0, 64'hA1 + c);
            else ddr_dout_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (ch_busy[1] !== 1'b1) begin errors++; $display("FAIL lock_ch1_busy: got %b want 1 (cycle %0d)", ch_busy[1], c); end
        end
        step();
        @(negedge clk);
        checks++;
        if (ch_busy !== 4'b1101 || ddr_we !== 1'b1 || ddr_addr !== 29'h300) begin
            errors++; $display("FAIL lock_gnt1: busy=%b we=%b addr=%h want 1101 1 300", ch_busy, ddr_we, ddr_addr);
        end
        step();
        ch_we[1] = 1'b0;
        @(negedge clk);
        wmon = 1'b0;
        checks++;
        if (ddr_we !== 1'b0 || wq.size() != 0 || rq.size() != 0) begin
            errors++; $display("FAIL lock_end: we=%b wq=%0d rq=%0d want 0 0 0", ddr_we, wq.size(), rq.size());
        end
    endtask

    task automatic test_zero_burst();
        step();
        set_ch(0, 1'b1, 1'b0, 29'h40, 8'd0, '1, '0);
        step();
        @(negedge clk);
        checks++;
        if (ddr_rd !== 1'b1 || ddr_addr !== 29'h40) begin
            errors++; $display("FAIL zero_cmd: rd=%b addr=%h want 1 40", ddr_rd, ddr_addr);
        end
        step();
        ch_rd[0] = 1'b0;
        beat(0, 64'h5A);
        step();
        ddr_dout = 64'h77;
        @(negedge clk);
        checks++;
        if (ch_dout_ready !== '0) begin errors++; $display("FAIL zero_extra: ready=%b want 0000", ch_dout_ready); end
        step();
        ddr_dout_ready = 1'b0;
        checks++;
        if (rq.size() != 0) begin errors++; $display("FAIL zero_missing: %0d beats left, want 0", rq.size()); end
    endtask

    task automatic test_round_robin();
        int ord[4] = '{1, 2, 3, 1};
        logic [CH-1:0] e, ef;
        step();
        for (int i = 1; i < CH; i++) set_ch(i, 1'b0, 1'b1, AW'(i * 16), 8'd1, '1, 64'(i));
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) ch_we = '0;
            @(negedge clk);
            e = '1;
            ef = '1;
            if (k % 2 == 0) begin
                e[ord[k/2]] = 1'b0;
                ef[1] = 1'b0;
            end
            checks++;
            if (ch_busy !== e) begin errors++; $display("FAIL rr_order: cycle %0d busy=%b want %b", k, ch_busy, e); end
            checks++;
            if (f_busy !== ef) begin errors++; $display("FAIL fixed_order: cycle %0d busy=%b want %b", k, f_busy, ef); end
        end
    endtask

    task automatic test_back_pressure();
        step();
        wmon = 1'b1;
        set_ch(2, 1'b0, 1'b1, 29'h500, 8'd3, 8'hFF, 64'hD0);
        set_ch(3, 1'b1, 1'b0, 29'h600, 8'd1, '1, '0);
        wq.push_back('{a: 29'h500, d: 64'hD0, be: 8'hFF});
        wq.push_back('{a: 29'h500, d: 64'hD1, be: 8'h0F});
        wq.push_back('{a: 29'h500, d: 64'hD2, be: 8'hF0});
        for (int c = 1; c <= 6; c++) begin
            step();
            case (c)
                2: begin ch_din[2*DW +: DW] = 64'hD1; ch_be[2*BEW +: BEW] = 8'h0F; ddr_busy = 1'b1; end
                4: ddr_busy = 1'b0;
                5: begin ch_din[2*DW +: DW] = 64'hD2; ch_be[2*BEW +: BEW] = 8'hF0; end
                6: begin ch_we[2] = 1'b0; ch_rd[3] = 1'b0; end
                default: ;
            endcase
            @(negedge clk);
            checks++;
            if (ch_busy[3] !== 1'b1) begin errors++; $display("FAIL bp_other: cycle %0d ch_busy[3]=%b want 1", c, ch_busy[3]); end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (ddr_addr !== 29'h500 || ddr_burstcnt !== 8'd3) begin
                    errors++; $display("FAIL bp_addr: cycle %0d addr=%h bc=%0d want 500 3", c, ddr_addr, ddr_burstcnt);
                end
            end
        end
        step();
        @(negedge clk);
        wmon = 1'b0;
        checks++;
        if (ddr_rd !== 1'b0 || ddr_we !== 1'b0 || wq.size() != 0) begin
            errors++; $display("FAIL bp_end: rd=%b we=%b beats_left=%0d want 0 0 0", ddr_rd, ddr_we, wq.size());
        end
    endtask

    task automatic test_reset_midburst();
        step();
        set_ch(0, 1'b1, 1'b0, 29'h700, 8'd4, '1, '0);
        step();
        step();
        ch_rd[0] = 1'b0;
        beat(0, 64'hB1);
        step();
        beat(0, 64'hB2);
        step();
        ddr_dout_ready = 1'b0;
        #1 rst_n = 1'b0;
        ddr_dout_ready = 1'b1;
        #1;
        checks++;
        if (ch_busy !== 4'hF || ch_dout_ready !== '0 || {ddr_rd, ddr_we, ddr_addr, ddr_burstcnt, ddr_be, ddr_din} !== '0) begin
            errors++; $display("FAIL async_reset: busy=%b ready=%b rd=%b addr=%h want 1111 0000 0 0", ch_busy, ch_dout_ready, ddr_rd, ddr_addr);
        end
        step();
        ddr_dout_ready = 1'b0;
        rst_n = 1'b1;
        step();
        set_ch(0, 1'b1, 1'b0, 29'h720, 8'd1, '1, '0);
        step();
        @(negedge clk);
        checks++;
        if (ddr_rd !== 1'b1 || ddr_addr !== 29'h720) begin
            errors++; $display("FAIL post_reset_cmd: rd=%b addr=%h want 1 720", ddr_rd, ddr_addr);
        end
        step();
        ch_rd[0] = 1'b0;
        beat(0, 64'hC3);
        step();
        ddr_dout = 64'hEE;
        @(negedge clk);
        checks++;
        if (ch_dout_ready !== '0) begin errors++; $display("FAIL post_reset_stray: ready=%b want 0000", ch_dout_ready); end
        step();
        ddr_dout_ready = 1'b0;
        checks++;
        if (rq.size() != 0) begin errors++; $display("FAIL post_reset_missing: %0d beats left, want 0", rq.size()); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_lock();
        test_zero_burst();
        test_round_robin();
        test_back_pressure();
        test_reset_midburst();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
